// File: rtl/conv33_sched_if.sv
// Handshake bundle between the layer controller / conv33 core and conv33_sched.
// master drives start/abort/conv_done; slave (the scheduler) drives the rest.
interface conv33_sched_if #(
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 start;
  logic                 abort;
  logic                 done;
  logic                 busy;
  logic                 conv_start;
  logic                 conv_done;
  logic [CNT_WIDTH-1:0] win_row;
  logic [CNT_WIDTH-1:0] win_col;
  logic [CNT_WIDTH-1:0] ch_idx;
  logic                 ch_first;
  logic [31:0]          perf_cycles;

  modport master (
    output start, abort, conv_done,
    input  done, busy, conv_start, win_row, win_col, ch_idx, ch_first, perf_cycles
  );

  modport slave (
    input  start, abort, conv_done,
    output done, busy, conv_start, win_row, win_col, ch_idx, ch_first, perf_cycles
  );
endinterface

// File: rtl/conv33_sched.sv
// Walks a 3x3 stride-1 window over an IMG_H x IMG_W map for NUM_CH kernels, one conv33 job each.
// Optional busy-cycle counter on perf_cycles enabled by CONV33_SCHED_PERF_EN.
module conv33_sched #(
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned IMG_H     = 28,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  conv33_sched_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0] ColLast = CNT_WIDTH'(IMG_W - 3);
  localparam logic [CNT_WIDTH-1:0] RowLast = CNT_WIDTH'(IMG_H - 3);
  localparam logic [CNT_WIDTH-1:0] ChLast  = CNT_WIDTH'(NUM_CH - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StAdvance, StFinish} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] row_q, row_d, col_q, col_d, ch_q, ch_d;
  logic                 done_q, done_d, busy_q, busy_d;
  logic                 cs_q, cs_d, first_q, first_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ch_d    = ch_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          state_d = StIssue;
          row_d   = '0;
          col_d   = '0;
          ch_d    = '0;
        end
      end
      StIssue: state_d = StWait;
      StWait:  if (bus.conv_done) state_d = StAdvance;
      StAdvance: begin
        state_d = StIssue;
        if (col_q < ColLast) begin
          col_d = col_q + CntOne;
        end else begin
          col_d = '0;
          if (row_q < RowLast) begin
            row_d = row_q + CntOne;
          end else begin
            row_d = '0;
            if (ch_q < ChLast) ch_d = ch_q + CntOne;
            else               state_d = StFinish;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Abort overrides every transition out of a busy state.
    if (state_q != StIdle && bus.abort) begin
      state_d = StIdle;
      row_d   = '0;
      col_d   = '0;
      ch_d    = '0;
    end
    busy_d  = (state_d != StIdle);
    cs_d    = (state_d == StIssue);
    done_d  = (state_d == StFinish);
    first_d = busy_d && (row_d == '0) && (col_d == '0);
  end

  // Outputs are registered alongside the state so nothing is combinational from inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      ch_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      first_q <= first_d;
    end
  end

  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.conv_start = cs_q;
  assign bus.win_row    = row_q;
  assign bus.win_col    = col_q;
  assign bus.ch_idx     = ch_q;
  assign bus.ch_first   = first_q;

`ifdef CONV33_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == StIdle) begin
      if (bus.start && !bus.abort) perf_d = '0;
    end else if (perf_q != 32'hFFFF_FFFF) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_conv33_sched.sv
// Directed bench for conv33_sched: a 5x4x2 instance walked through a window table and a
// 3x3x1 instance for the minimal-map latency and perf_cycles checks.
module tb_conv33_sched;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   a_cs   = 0;
  int   a_dn   = 0;

  conv33_sched_if #(.CNT_WIDTH(8)) a_if ();
  conv33_sched_if #(.CNT_WIDTH(8)) b_if ();

  conv33_sched #(.IMG_W(5), .IMG_H(4), .NUM_CH(2), .CNT_WIDTH(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  conv33_sched #(.IMG_W(3), .IMG_H(3), .NUM_CH(1), .CNT_WIDTH(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_if.conv_start === 1'b1) a_cs <= a_cs + 1;
    if (a_if.done === 1'b1)       a_dn <= a_dn + 1;
  end

  typedef struct {
    int lat;
    int ch;
    int row;
    int col;
    int first;
  } vec_t;

  vec_t vt[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // One layer on dut_a; noise adds spurious start/conv_done, abort_win aborts on that window.
  task automatic run_a(input bit noise, input int abort_win);
    int cs0, dn0;
    bit aborted;
    cs0 = a_cs;
    dn0 = a_dn;
    aborted = 1'b0;
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
    for (int w = 0; w < 12 && !aborted; w++) begin
      chk("a_issue_cs", int'(a_if.conv_start), 1);
      chk("a_issue_ch", int'(a_if.ch_idx), vt[w].ch);
      chk("a_issue_row", int'(a_if.win_row), vt[w].row);
      chk("a_issue_col", int'(a_if.win_col), vt[w].col);
      chk("a_issue_first", int'(a_if.ch_first), vt[w].first);
      if (noise) begin
        a_if.conv_done = 1'b1;
        a_if.start     = 1'b1;
      end
      for (int j = 0; j < vt[w].lat; j++) begin
        step();
        a_if.conv_done = 1'b0;
        a_if.start     = noise;
      end
      chk("a_wait_busy", int'(a_if.busy), 1);
      chk("a_wait_cs", int'(a_if.conv_start), 0);
      chk("a_wait_col", int'(a_if.win_col), vt[w].col);
      a_if.start     = 1'b0;
      a_if.conv_done = 1'b1;
      if (w == abort_win) begin
        a_if.abort = 1'b1;
        aborted    = 1'b1;
      end
      step();
      a_if.conv_done = 1'b0;
      a_if.abort     = 1'b0;
      if (aborted) begin
        chk("a_abort_busy", int'(a_if.busy), 0);
        chk("a_abort_done", int'(a_if.done), 0);
        chk("a_abort_row", int'(a_if.win_row), 0);
        chk("a_abort_col", int'(a_if.win_col), 0);
        chk("a_abort_ch", int'(a_if.ch_idx), 0);
      end else begin
        chk("a_adv_cs", int'(a_if.conv_start), 0);
        if (noise) begin
          a_if.conv_done = 1'b1;
          a_if.start     = 1'b1;
        end
        step();
        a_if.conv_done = 1'b0;
        a_if.start     = 1'b0;
      end
    end
    if (!aborted) begin
      chk("a_done", int'(a_if.done), 1);
      chk("a_done_busy", int'(a_if.busy), 1);
      step();
      chk("a_done_pulse", int'(a_if.done), 0);
      chk("a_idle_busy", int'(a_if.busy), 0);
      chk("a_cs_count", a_cs - cs0, 12);
      chk("a_done_count", a_dn - dn0, 1);
    end else begin
      repeat (8) step();
      chk("a_abort_cs_count", a_cs - cs0, abort_win + 1);
      chk("a_abort_done_count", a_dn - dn0, 0);
    end
  endtask

  initial begin
    int exp_perf;
    vt[0]  = '{3, 0, 0, 0, 1};
    vt[1]  = '{3, 0, 0, 1, 0};
    vt[2]  = '{3, 0, 0, 2, 0};
    vt[3]  = '{3, 0, 1, 0, 0};
    vt[4]  = '{3, 0, 1, 1, 0};
    vt[5]  = '{3, 0, 1, 2, 0};
    vt[6]  = '{3, 1, 0, 0, 1};
    vt[7]  = '{3, 1, 0, 1, 0};
    vt[8]  = '{3, 1, 0, 2, 0};
    vt[9]  = '{3, 1, 1, 0, 0};
    vt[10] = '{3, 1, 1, 1, 0};
    vt[11] = '{3, 1, 1, 2, 0};

    rst = 1'b1;
    a_if.start = 1'b0; a_if.abort = 1'b0; a_if.conv_done = 1'b0;
    b_if.start = 1'b0; b_if.abort = 1'b0; b_if.conv_done = 1'b0;
    repeat (2) step();
    chk("rst_busy", int'(a_if.busy), 0);
    chk("rst_done", int'(a_if.done), 0);
    chk("rst_cs", int'(a_if.conv_start), 0);
    chk("rst_first", int'(a_if.ch_first), 0);
    chk("rst_perf", int'(a_if.perf_cycles), 0);
    rst = 1'b0;
    step();

    // Asynchronous reset while waiting on the core.
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
    step();
    chk("pre_rst_busy", int'(a_if.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(a_if.busy), 0);
    chk("async_rst_first", int'(a_if.ch_first), 0);
    step();
    rst = 1'b0;
    repeat (4) step();
    chk("post_rst_idle", int'(a_if.busy), 0);
    chk("post_rst_done", a_dn, 0);

    run_a(1'b0, -1);
    run_a(1'b1, -1);
    run_a(1'b0, 4);

    a_if.start = 1'b1;
    a_if.abort = 1'b1;
    step();
    a_if.start = 1'b0;
    a_if.abort = 1'b0;
    chk("idle_abort_busy", int'(a_if.busy), 0);
    chk("idle_abort_cs", int'(a_if.conv_start), 0);
    step();
    run_a(1'b0, -1);

    // Minimal 3x3x1 map, conv_done one cycle after conv_start.
`ifdef CONV33_SCHED_PERF_EN
    exp_perf = 4;
`else
    exp_perf = 0;
`endif
    b_if.start = 1'b1;
    step();
    b_if.start = 1'b0;
    chk("b_c1_cs", int'(b_if.conv_start), 1);
    chk("b_c1_busy", int'(b_if.busy), 1);
    chk("b_c1_first", int'(b_if.ch_first), 1);
    step();
    chk("b_c2_cs", int'(b_if.conv_start), 0);
    b_if.conv_done = 1'b1;
    step();
    b_if.conv_done = 1'b0;
    chk("b_c3_busy", int'(b_if.busy), 1);
    chk("b_c3_done", int'(b_if.done), 0);
    step();
    chk("b_c4_done", int'(b_if.done), 1);
    chk("b_c4_busy", int'(b_if.busy), 1);
    step();
    chk("b_c5_done", int'(b_if.done), 0);
    chk("b_c5_busy", int'(b_if.busy), 0);
    chk("b_perf", int'(b_if.perf_cycles), exp_perf);
    repeat (5) step();
    chk("b_perf_hold", int'(b_if.perf_cycles), exp_perf);
    chk("b_idle_cs", int'(b_if.conv_start), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv33_sched.md
Name: conv33_sched

Overview:
Layer-level scheduler for the conv33 core. It walks a 3x3 window over an IMG_H x IMG_W feature map for NUM_CH kernels: stride 1, no padding. For each window it publishes the window's top-left coordinates and kernel index, pulses the core's start, and waits for the core's done. It sits between the layer controller (start/done/abort) and one conv33 instance plus its feature/weight fetch logic.

Parameters:
IMG_W, 28, input map width in pixels (>=3)
IMG_H, 28, input map height in pixels (>=3)
NUM_CH, 4, number of kernels/output channels processed back to back (>=1)
CNT_WIDTH, 8, width of row/col/channel counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin layer; sampled only in IDLE
abort  in  1  synchronous abort; return to IDLE next cycle, no done
done  out  1  one-cycle pulse, layer complete
busy  out  1  high in every state except IDLE
conv_start  out  1  one-cycle start pulse to conv33
conv_done  in  1  done from conv33; sampled only in WAIT
win_row  out  CNT_WIDTH  top-left row of current window
win_col  out  CNT_WIDTH  top-left col of current window
ch_idx  out  CNT_WIDTH  current kernel index
ch_first  out  1  high while the current window is the first of its channel (weight reload hint)
perf_cycles  out  32  busy-cycle count (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0: done, busy, conv_start, win_row, win_col, ch_idx, ch_first, perf_cycles.
- Reset mid-operation discards all progress. No done is produced.
- All outputs are registered or Moore-decoded from the state. No combinational path from inputs to outputs.
- Output map: (IMG_H-2) rows x (IMG_W-2) cols per channel. Total conv_start pulses per layer = NUM_CH*(IMG_H-2)*(IMG_W-2).
- States:
  - IDLE: start=1 -> ISSUE. Counters are cleared on entry to ISSUE from IDLE.
  - ISSUE: conv_start=1 for exactly this cycle -> WAIT.
  - WAIT: conv_done=1 -> ADVANCE; otherwise stay. No timeout.
  - ADVANCE:
    - col < IMG_W-3: col++ -> ISSUE.
    - Else col=0. If row < IMG_H-3: row++ -> ISSUE.
    - Else row=0. If ch < NUM_CH-1: ch++ -> ISSUE.
    - Else -> FINISH.
  - FINISH: done=1 for one cycle -> IDLE. Counters hold their last values.
- Latency:
  - start sampled at edge k -> conv_start high in cycle k+1.
  - conv_done sampled at edge t -> next conv_start high in cycle t+2, or done high in cycle t+2 for the final window.
- win_row, win_col, ch_idx are stable from ISSUE through WAIT of each window. They change only on leaving ADVANCE.
- ch_first = (win_row==0 && win_col==0) while busy.
- start while busy: ignored.
- conv_done outside WAIT (including in ISSUE): ignored.
- abort has priority over every transition, including conv_done in WAIT. Next state is IDLE, no done pulse, counters cleared. abort in IDLE has no effect.
- start and abort both high in IDLE: abort wins, stay IDLE.
- Minimal map IMG_W=IMG_H=3, NUM_CH=1: exactly one window (0,0,0).

Optional Feature:
Macro CONV33_SCHED_PERF_EN.
- Defined: perf_cycles clears to 0 when start is accepted, then increments by 1 every cycle busy=1, including the FINISH cycle. It holds its value in IDLE until the next accepted start. It saturates at 0xFFFFFFFF. abort leaves the value frozen.
- Undefined: perf_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- Reset mid-WAIT -> all outputs 0 immediately (asynchronous). After release, stays IDLE until a new start. No done pulse.
- IMG_W=5, IMG_H=4, NUM_CH=2, conv_done returned 3 cycles after each conv_start -> 12 conv_start pulses with (ch,row,col) order (0,0,0),(0,0,1),(0,0,2),(0,1,0),(0,1,1),(0,1,2),(1,0,0)...(1,1,2). ch_first high only on (0,0,0) and (1,0,0). One done, 2 cycles after the 12th conv_done.
- IMG_W=IMG_H=3, NUM_CH=1, conv_done 1 cycle after conv_start -> single conv_start at cycle 1, done at cycle 4, busy high cycles 1-4.
- Same config as the second test, start re-pulsed mid-layer and spurious conv_done pulsed during ISSUE and ADVANCE -> sequence and pulse count unchanged.
- abort asserted in the same cycle as conv_done during the 5th window -> IDLE next cycle, no done, no further conv_start. A following start restarts at (0,0,0).
- With CONV33_SCHED_PERF_EN, IMG_W=IMG_H=3, NUM_CH=1, conv_done latency 1 -> perf_cycles=4 after done, holding through IDLE. Without the macro -> perf_cycles stays 0.
